// File: rtl/tanhshrink_pkg.sv
// Shared types, constants and elaboration-time helpers for the tanhshrink LUT stream.
// The LUT contents are generated here with integer fixed-point math so no real arithmetic reaches synthesis.
package tanhshrink_pkg;

  localparam int W_IN   = 16;
  localparam int F_BITS = 8;
  localparam int W_OUT  = 16;
  localparam int A_BITS = 11;
  localparam int LUT_Q  = 30;
  localparam int ONE_FX = 1 << F_BITS;

  typedef logic signed [W_IN-1:0]  in_lane_t;
  typedef logic signed [W_OUT-1:0] out_lane_t;
  typedef logic        [W_IN-2:0]  mag_t;

  // round-half-away(m/2^f - tanh(m/2^f)) * 2^f, using tanh(x) = (1 - e^-2x) / (1 + e^-2x) in Q30
  function automatic int lut_entry(input int m, input int f);
    longint unsigned one, base, term, e, pw, t, lhs, rhs;
    one  = 64'd1 << LUT_Q;
    base = one;
    term = one;
    for (int n = 1; n < 12; n++) begin
      term = term / ((64'd1 << (f - 1)) * 64'(n));
      if (n % 2 == 1) base = base - term;
      else            base = base + term;
    end
    e  = one;
    pw = base;
    for (int k = 0; k < 31; k++) begin
      if (((m >> k) & 1) != 0) e = (e * pw) >> LUT_Q;
      pw = (pw * pw) >> LUT_Q;
    end
    t   = ((one - e) << LUT_Q) / (one + e);
    lhs = 64'(m) << LUT_Q;
    rhs = t << f;
    if (rhs >= lhs) return 0;
    return int'(((lhs - rhs) + (one >> 1)) >> LUT_Q);
  endfunction

  function automatic logic signed [31:0] sat_out(input logic signed [31:0] v, input int wo);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (wo - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (wo - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/tanhshrink_mag_rom.sv
// Combinational half-range magnitude ROM: data = x - tanh(x) for x = addr / 2^FRAC.
// Contents are elaborated from tanhshrink_pkg::lut_entry.
module tanhshrink_mag_rom
  import tanhshrink_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int FRAC   = 8
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] data
);

  logic [ADDR_W-1:0] rom [2**ADDR_W];

  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_entry
    localparam int ENTRY = lut_entry(i, FRAC);
    assign rom[i] = ENTRY[ADDR_W-1:0];
  end

  assign data = rom[addr];

endmodule

// File: rtl/tanhshrink_lut_stream.sv
// Streaming tanhshrink y = x - tanh(x), P lanes per beat, 2-stage elastic pipeline.
// Optional lin_count statistics port under TANHSHRINK_LUT_STREAM_STATS_EN.
module tanhshrink_lut_stream
  import tanhshrink_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0  = W_IN,
  parameter int DATA_IN_0_PRECISION_1  = F_BITS,
  parameter int DATA_OUT_0_PRECISION_0 = W_OUT,
  parameter int DATA_OUT_0_PRECISION_1 = F_BITS,
  parameter int DATA_IN_0_PARALLELISM  = 4,
  parameter int LUT_ADDR_WIDTH         = A_BITS
) (
  input  logic                                                     clk,
  input  logic                                                     rst_n,
  input  logic [DATA_IN_0_PARALLELISM*DATA_IN_0_PRECISION_0-1:0]   data_in_0,
  input  logic                                                     data_in_0_valid,
  output logic                                                     data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM*DATA_OUT_0_PRECISION_0-1:0]  data_out_0,
  output logic                                                     data_out_0_valid,
  input  logic                                                     data_out_0_ready
`ifdef TANHSHRINK_LUT_STREAM_STATS_EN
  ,
  output logic [31:0]                                              lin_count
`endif
);

  localparam int W  = DATA_IN_0_PRECISION_0;
  localparam int F  = DATA_IN_0_PRECISION_1;
  localparam int WO = DATA_OUT_0_PRECISION_0;
  localparam int P  = DATA_IN_0_PARALLELISM;
  localparam int A  = LUT_ADDR_WIDTH;
  localparam logic signed [31:0] ONE = 32'sd1 <<< F;

  if (DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1) begin : g_err_frac
    $error("tanhshrink_lut_stream: output fractional bits must equal input fractional bits");
  end
  if (A < F + 3 || A > W - 1) begin : g_err_addr
    $error("tanhshrink_lut_stream: LUT_ADDR_WIDTH out of range");
  end

  // Handshake: a beat moves on a clock edge where valid && ready. Stage 2 (the output
  // register, whose valid is data_out_0_valid) loads when empty or drained; stage 1
  // loads when empty or stage 2 loads, so data_in_0_ready follows data_out_0_ready.
  logic s1_valid;
  logic s1_load;
  logic s2_load;

  assign s2_load         = !data_out_0_valid || data_out_0_ready;
  assign s1_load         = !s1_valid || s2_load;
  assign data_in_0_ready = s1_load;

  logic [W-2:0]  mag_c  [P];
  logic [P-1:0]  sgn_c;
  logic [P-1:0]  inr_c;
  logic [W-2:0]  s1_mag [P];
  logic [P-1:0]  s1_sgn;
  logic [P-1:0]  s1_inr;
  logic [A-1:0]  rom_q  [P];
  logic [WO-1:0] y_c    [P];

  for (genvar i = 0; i < P; i++) begin : g_lane
    logic [W-1:0]       x;
    logic [W-1:0]       neg;
    logic signed [31:0] ymag;
    logic signed [31:0] y;
    logic signed [31:0] ys;

    assign x        = data_in_0[i*W +: W];
    assign neg      = -x;
    assign sgn_c[i] = x[W-1];
    // Negating the most-negative input overflows; clamp its magnitude to the largest positive value.
    assign mag_c[i] = !x[W-1] ? x[W-2:0] : (neg[W-1] ? {(W-1){1'b1}} : neg[W-2:0]);
    assign inr_c[i] = (32'(mag_c[i]) < (32'd1 << A));

    tanhshrink_mag_rom #(
      .ADDR_W (A),
      .FRAC   (F)
    ) u_rom (
      .addr (s1_mag[i][A-1:0]),
      .data (rom_q[i])
    );

    // Past the LUT range tanh(x) is 1.0 to within half an LSB, so the asymptote is exact.
    assign ymag     = s1_inr[i] ? 32'(rom_q[i]) : 32'(s1_mag[i]) - ONE;
    assign y        = s1_sgn[i] ? -ymag : ymag;
    assign ys       = sat_out(y, WO);
    assign y_c[i]   = ys[WO-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid         <= 1'b0;
      s1_sgn           <= '0;
      s1_inr           <= '0;
      for (int i = 0; i < P; i++) s1_mag[i] <= '0;
      data_out_0_valid <= 1'b0;
      data_out_0       <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= data_in_0_valid;
        if (data_in_0_valid) begin
          s1_sgn <= sgn_c;
          s1_inr <= inr_c;
          for (int i = 0; i < P; i++) s1_mag[i] <= mag_c[i];
        end
      end
      if (s2_load) begin
        data_out_0_valid <= s1_valid;
        if (s1_valid) begin
          for (int i = 0; i < P; i++) data_out_0[i*WO +: WO] <= y_c[i];
        end
      end
    end
  end

`ifdef TANHSHRINK_LUT_STREAM_STATS_EN
  logic [31:0] lin_add;
  logic [32:0] lin_sum;

  always_comb begin
    lin_add = '0;
    for (int i = 0; i < P; i++) lin_add = lin_add + 32'(!s1_inr[i]);
    lin_sum = {1'b0, lin_count} + {1'b0, lin_add};
  end

  // Counted as each beat passes from stage 1 into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lin_count <= '0;
    end else if (s1_valid && s2_load) begin
      lin_count <= lin_sum[32] ? 32'hFFFF_FFFF : lin_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_tanhshrink_lut_stream.sv
// Self-checking bench for tanhshrink_lut_stream: directed corner beats plus randomized
// streaming against a real-arithmetic tanh model, with stall, throughput and reset checks.
module tb_tanhshrink_lut_stream;
  import tanhshrink_pkg::*;

  localparam int W = 16;
  localparam int P = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [P*W-1:0] data_in_0 = '0;
  logic           data_in_0_valid = 1'b0;
  logic           data_in_0_ready;
  logic [P*W-1:0] data_out_0;
  logic           data_out_0_valid;
  logic           data_out_0_ready = 1'b1;
`ifdef TANHSHRINK_LUT_STREAM_STATS_EN
  logic [31:0]    lin_count;
`endif

  always #5 clk = ~clk;

  tanhshrink_lut_stream dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready)
`ifdef TANHSHRINK_LUT_STREAM_STATS_EN
    ,
    .lin_count        (lin_count)
`endif
  );

  int             n_cmp = 0;
  int             n_bad = 0;
  int             ready_mode = 0;
  int             cyc = 0;
  int             acc_edge = 0;
  int             last_out_edge = 0;
  int             exp_lin = 0;
  logic [P*W-1:0] exp_q [$];
  logic [P-1:0]   inr_q [$];
  logic [P*W-1:0] last_beat = '0;
  logic [P*W-1:0] prev_data = '0;
  logic           stall = 1'b0;
  logic [P*W-1:0] mon_e;
  logic [P-1:0]   mon_inr;

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    n_cmp++;
    if (got - exp > tol || exp - got > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at t=%0t", tag, got, exp, tol, $time);
    end
  endtask

  // Reference: tanhshrink from real tanh, linear asymptote past 2^A, odd symmetry, clamp.
  function automatic int model_lane(input logic [W-1:0] x, output bit inr);
    int  xs, m, ymag, y;
    real r;
    xs = int'($signed(x));
    m  = (xs == -32768) ? 32767 : (xs < 0 ? -xs : xs);
    if (m < (1 << A_BITS)) begin
      r    = (real'(m) / real'(ONE_FX) - $tanh(real'(m) / real'(ONE_FX))) * real'(ONE_FX);
      ymag = int'($floor(r + 0.5));
      inr  = 1'b1;
    end else begin
      ymag = m - ONE_FX;
      inr  = 1'b0;
    end
    y = (xs < 0) ? -ymag : ymag;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic push_exp(input logic [P*W-1:0] beat);
    logic [P*W-1:0] e;
    logic [P-1:0]   f;
    bit             b;
    int             v;
    for (int i = 0; i < P; i++) begin
      v = model_lane(beat[i*W +: W], b);
      e[i*W +: W] = v[W-1:0];
      f[i] = b;
    end
    exp_q.push_back(e);
    inr_q.push_back(f);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       data_out_0_ready = 1'b1;
        1:       data_out_0_ready = 1'($urandom_range(0, 1));
        default: data_out_0_ready = 1'b0;
      endcase
    end
  end

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_valid_hold", int'(data_out_0_valid), 1);
        for (int i = 0; i < P; i++)
          check("stall_data_hold", int'($signed(data_out_0[i*W +: W])), int'($signed(prev_data[i*W +: W])));
      end
      if (data_out_0_valid && data_out_0_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_inr = inr_q.pop_front();
          for (int i = 0; i < P; i++) begin
            check("lane_value", int'($signed(data_out_0[i*W +: W])), int'($signed(mon_e[i*W +: W])),
                  mon_inr[i] ? 1 : 0);
            exp_lin += mon_inr[i] ? 0 : 1;
          end
        end
        last_beat     = data_out_0;
        last_out_edge = cyc + 1;
      end
      stall     = data_out_0_valid && !data_out_0_ready;
      prev_data = data_out_0;
    end
  end

  task automatic send(input logic [P*W-1:0] beat, input int max_wait);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    data_in_0 = beat;
    data_in_0_valid = 1'b1;
    while (!done && n < max_wait) begin
      @(negedge clk);
      if (data_in_0_ready) begin
        push_exp(beat);
        acc_edge = cyc + 1;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    data_in_0_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      inr_q.delete();
    end
  endtask

  function automatic logic [W-1:0] rand_lane();
    int v;
    case ($urandom_range(0, 3))
      0: v = int'($urandom_range(0, 65535));
      1: v = int'($urandom_range(0, 4200)) - 2100;
      2: v = int'($urandom_range(0, 600)) - 300;
      default: begin
        case ($urandom_range(0, 7))
          0: v = 0;
          1: v = -32768;
          2: v = 32767;
          3: v = 2047;
          4: v = 2048;
          5: v = -2048;
          6: v = -2047;
          default: v = 1;
        endcase
      end
    endcase
    return v[W-1:0];
  endfunction

  function automatic logic [P*W-1:0] rand_beat();
    logic [P*W-1:0] b;
    for (int i = 0; i < P; i++) b[i*W +: W] = rand_lane();
    return b;
  endfunction

  function automatic int lane_of(input logic [P*W-1:0] b, input int i);
    return int'($signed(b[i*W +: W]));
  endfunction

  int             acc;
  int             first_acc;
  logic [P*W-1:0] beat;

  initial begin
    // Reset state
    #3;
    check("rst_out_valid", int'(data_out_0_valid), 0);
    check("rst_out_data", int'(data_out_0 != '0), 0);
    check("rst_in_ready", int'(data_in_0_ready), 1);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic lanes, with 2-cycle latency
    send({16'h0080, 16'hFF00, 16'h0100, 16'h0000}, 10);
    @(negedge clk);
    check("latency_not_early", int'(data_out_0_valid), 0);
    @(negedge clk);
    check("latency_2cyc", int'(data_out_0_valid), 1);
    wait_drain(20);
    check("basic_lane0", lane_of(last_beat, 0), 0);
    check("basic_lane1", lane_of(last_beat, 1), 61);
    check("basic_lane2", lane_of(last_beat, 2), -61);
    check("basic_lane3", lane_of(last_beat, 3), 10);

    // Linear region and extremes
    send({16'h8000, 16'h7FFF, 16'hF400, 16'h0C00}, 10);
    wait_drain(20);
    check("lin_lane0", lane_of(last_beat, 0), 2816);
    check("lin_lane1", lane_of(last_beat, 1), -2816);
    check("lin_lane2", lane_of(last_beat, 2), 32511);
    check("lin_lane3", lane_of(last_beat, 3), -32511);
`ifdef TANHSHRINK_LUT_STREAM_STATS_EN
    check("lin_count_4", int'(lin_count), 4);
`endif

    // LUT boundary: 2047, 2048, -2047, -2048
    send({16'hF800, 16'hF801, 16'h0800, 16'h07FF}, 10);
    wait_drain(20);
    check("bnd_2047", lane_of(last_beat, 0), 1791);
    check("bnd_2048", lane_of(last_beat, 1), 1792);
    check("bnd_m2047", lane_of(last_beat, 2), -1791);
    check("bnd_m2048", lane_of(last_beat, 3), -1792);
    check("bnd_monotonic", int'(lane_of(last_beat, 1) >= lane_of(last_beat, 0)), 1);

    // Backpressure: 10 beats, random 50% ready
    ready_mode = 1;
    for (int k = 0; k < 10; k++) send(rand_beat(), 200);
    wait_drain(300);

    // Ready held low: only two beats fit
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    acc = 0;
    beat = rand_beat();
    for (int c = 0; c < 3; c++) begin
      data_in_0 = beat;
      data_in_0_valid = 1'b1;
      @(negedge clk);
      if (data_in_0_ready) begin
        push_exp(beat);
        acc++;
        beat = rand_beat();
      end
      @(posedge clk);
      #1;
    end
    data_in_0_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready_low", int'(data_in_0_ready), 0);
    check("full_accepts_2", acc, 2);
    ready_mode = 0;
    wait_drain(50);
`ifdef TANHSHRINK_LUT_STREAM_STATS_EN
    check("lin_count_bp", int'(lin_count), exp_lin);
`endif

    // Throughput: 100 back-to-back beats with ready high
    repeat (2) @(posedge clk);
    #1;
    first_acc = 0;
    for (int k = 0; k < 100; k++) begin
      send(rand_beat(), 5);
      if (k == 0) first_acc = acc_edge;
    end
    wait_drain(50);
    check("throughput_edges", last_out_edge - first_acc, 101);

    // Reset with two beats in flight
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(rand_beat(), 10);
    send(rand_beat(), 10);
    @(negedge clk);
    check("pre_reset_valid", int'(data_out_0_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", int'(data_out_0_valid), 0);
    check("async_reset_ready", int'(data_in_0_ready), 1);
    exp_q.delete();
    inr_q.delete();
    exp_lin = 0;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(rand_beat(), 10);
    @(negedge clk);
    check("post_reset_not_early", int'(data_out_0_valid), 0);
    @(negedge clk);
    check("post_reset_latency", int'(data_out_0_valid), 1);
    wait_drain(20);
`ifdef TANHSHRINK_LUT_STREAM_STATS_EN
    check("lin_count_after_reset", int'(lin_count), exp_lin);
`endif

    // Randomized soak with gaps and random backpressure
    ready_mode = 1;
    for (int k = 0; k < 150; k++) begin
      send(rand_beat(), 200);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_drain(500);
`ifdef TANHSHRINK_LUT_STREAM_STATS_EN
    check("lin_count_soak", int'(lin_count), exp_lin);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
